// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm bank: set-time/current-time field layout,
// value limits, entry width and ring FSM encoding.
package alarm_pkg;

    localparam int STI_W     = 16;
    localparam int CT_W      = 15;
    localparam int ENTRY_W   = 13;
    localparam int TIME_W    = 12;
    localparam int NUM_DAYS  = 7;
    localparam int CNT_W     = 4;

    localparam int EN_BIT    = 15;
    localparam int DAY_LSB   = 12;
    localparam int DAY_W     = 3;
    localparam int HOUR_LSB  = 7;
    localparam int HOUR_W    = 5;
    localparam int TENS_LSB  = 4;
    localparam int TENS_W    = 3;
    localparam int UNITS_LSB = 0;
    localparam int UNITS_W   = 4;

    localparam logic [DAY_W-1:0]   DAY_MAX   = 3'd6;
    localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
    localparam logic [TENS_W-1:0]  TENS_MAX  = 3'd5;
    localparam logic [UNITS_W-1:0] UNITS_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_t;

    // A set-time word is storable only if every field is inside its range.
    function automatic logic sti_valid(input logic [STI_W-1:0] sti);
        return (sti[DAY_LSB   +: DAY_W]   <= DAY_MAX)  &&
               (sti[HOUR_LSB  +: HOUR_W]  <= HOUR_MAX) &&
               (sti[TENS_LSB  +: TENS_W]  <= TENS_MAX) &&
               (sti[UNITS_LSB +: UNITS_W] <= UNITS_MAX);
    endfunction

    // Stored entry drops the day field: {enable, hour, tens, units}.
    function automatic logic [ENTRY_W-1:0] entry_of(input logic [STI_W-1:0] sti);
        return {sti[EN_BIT], sti[TIME_W-1:0]};
    endfunction

endpackage

// File: rtl/minute_down_counter.sv
// Loadable 4-bit down counter; terminal flags the tick that exhausts the count.
module minute_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       terminal
);

    logic [3:0] count;

    // Load wins over decrement; the count parks at zero once exhausted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // The tick that sees a count of one is the last tick of the interval.
    assign terminal = (count == 4'd1);

endmodule

// File: rtl/alarm_bank.sv
// Per-weekday alarm storage with write validation, minute match and the
// ring/snooze state machine driving the buzzer.
import alarm_pkg::*;

module alarm_bank #(
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9
) (
    input  logic                Clk,
    input  logic                CLEAR,
    input  logic [STI_W-1:0]    STI,
    input  logic                WR_AL,
    input  logic [CT_W-1:0]     CT,
    input  logic                MIN_TICK,
    input  logic                STOP,
    input  logic                SNOOZE,
    output logic [ENTRY_W-1:0]  Q_r0,
    output logic [ENTRY_W-1:0]  Q_r1,
    output logic [ENTRY_W-1:0]  Q_r2,
    output logic [ENTRY_W-1:0]  Q_r3,
    output logic [ENTRY_W-1:0]  Q_r4,
    output logic [ENTRY_W-1:0]  Q_r5,
    output logic [ENTRY_W-1:0]  Q_r6,
    output logic                ALARM,
    output logic                ERR
);

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_MIN);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_MIN);

    logic [ENTRY_W-1:0] entry [NUM_DAYS];
    logic [ENTRY_W-1:0] today;
    logic               match;
    logic               sti_ok;
    alarm_state_t       state;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_en;
    logic               cnt_term;

    assign sti_ok = sti_valid(STI);

    // Select today's entry; a day code of 7 selects nothing and never matches.
    always_comb begin
        today = '0;
        for (int d = 0; d < NUM_DAYS; d++) begin
            if (CT[DAY_LSB +: DAY_W] == DAY_W'(d)) begin
                today = entry[d];
            end
        end
    end

    // Compare against the stored entry as it stood before any same-cycle write.
    assign match = MIN_TICK && today[ENTRY_W-1] && (today[TIME_W-1:0] == CT[TIME_W-1:0]);

    // Entry storage with per-day write decode; invalid words leave it untouched.
    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            for (int d = 0; d < NUM_DAYS; d++) begin
                entry[d] <= '0;
            end
        end else if (WR_AL && sti_ok) begin
            for (int d = 0; d < NUM_DAYS; d++) begin
                if (STI[DAY_LSB +: DAY_W] == DAY_W'(d)) begin
                    entry[d] <= entry_of(STI);
                end
            end
        end
    end

    // One-cycle reject pulse following a bad write strobe.
    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            ERR <= 1'b0;
        end else begin
            ERR <= WR_AL && !sti_ok;
        end
    end

    // Counter control: load the interval on entry to a timed state, count ticks otherwise.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = RING_LD;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_load = match;
            end
            ST_RINGING: begin
                if (!STOP) begin
                    if (SNOOZE) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = SNOOZE_LD;
                    end else begin
                        cnt_en = MIN_TICK;
                    end
                end
            end
            ST_SNOOZED: begin
                if (!STOP) begin
                    if (MIN_TICK && cnt_term) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_en = MIN_TICK;
                    end
                end
            end
            default: ;
        endcase
    end

    minute_down_counter u_cnt (
        .clk      (Clk),
        .rst      (CLEAR),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .terminal (cnt_term)
    );

    // Ring/snooze FSM with the buzzer drive registered alongside the state.
    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            state <= ST_IDLE;
            ALARM <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        state <= ST_RINGING;
                        ALARM <= 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        ALARM <= 1'b0;
                    end else if (SNOOZE) begin
                        state <= ST_SNOOZED;
                        ALARM <= 1'b0;
                    end else if (MIN_TICK && cnt_term) begin
                        state <= ST_IDLE;
                        ALARM <= 1'b0;
                    end
                end
                ST_SNOOZED: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        ALARM <= 1'b0;
                    end else if (MIN_TICK && cnt_term) begin
                        state <= ST_RINGING;
                        ALARM <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ALARM <= 1'b0;
                end
            endcase
        end
    end

    assign Q_r0 = entry[0];
    assign Q_r1 = entry[1];
    assign Q_r2 = entry[2];
    assign Q_r3 = entry[3];
    assign Q_r4 = entry[4];
    assign Q_r5 = entry[5];
    assign Q_r6 = entry[6];

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: a behavioural reference model pushes the expected
// outputs of every cycle to a scoreboard; each scenario pops and compares.
module tb_alarm_bank;

    localparam int RING   = 5;
    localparam int SNOOZE = 9;

    typedef logic [92:0] obs_t;

    logic        Clk = 1'b0;
    logic        CLEAR = 1'b0;
    logic [15:0] STI = '0;
    logic        WR_AL = 1'b0;
    logic [14:0] CT = '0;
    logic        MIN_TICK = 1'b0;
    logic        STOP = 1'b0;
    logic        SNOOZE_B = 1'b0;
    logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
    logic        ALARM, ERR;

    int checks = 0;
    int failures = 0;

    obs_t sb[$];
    obs_t exp_o;
    obs_t dut_obs;

    // Reference model state (counts up, as the behaviour is described).
    logic [12:0] m_q [8];
    int          m_state;
    int          m_cnt;
    logic        m_alarm;
    logic        m_err;

    localparam logic [14:0] CT_HIT  = {3'd1, 12'hA15};
    localparam logic [14:0] CT_MISS = {3'd1, 12'hA16};

    assign dut_obs = {ALARM, ERR, Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6};

    alarm_bank #(.RING_MIN(RING), .SNOOZE_MIN(SNOOZE)) dut (
        .Clk      (Clk),
        .CLEAR    (CLEAR),
        .STI      (STI),
        .WR_AL    (WR_AL),
        .CT       (CT),
        .MIN_TICK (MIN_TICK),
        .STOP     (STOP),
        .SNOOZE   (SNOOZE_B),
        .Q_r0     (Q_r0),
        .Q_r1     (Q_r1),
        .Q_r2     (Q_r2),
        .Q_r3     (Q_r3),
        .Q_r4     (Q_r4),
        .Q_r5     (Q_r5),
        .Q_r6     (Q_r6),
        .ALARM    (ALARM),
        .ERR      (ERR)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of inputs, advance the model, push its expectation,
    // then wait until just after the edge so outputs can be sampled.
    task automatic drive(input logic clr, input logic [15:0] sti, input logic wr,
                         input logic [14:0] ct, input logic tick,
                         input logic stp, input logic snz);
        logic hit;
        logic ok;
        CLEAR = clr; STI = sti; WR_AL = wr; CT = ct;
        MIN_TICK = tick; STOP = stp; SNOOZE_B = snz;
        if (clr) begin
            for (int i = 0; i < 8; i++) m_q[i] = '0;
            m_state = 0; m_cnt = 0; m_alarm = 1'b0; m_err = 1'b0;
        end else begin
            hit = tick && (ct[14:12] != 3'd7) && m_q[ct[14:12]][12] &&
                  (m_q[ct[14:12]][11:0] == ct[11:0]);
            m_err = 1'b0;
            if (wr) begin
                ok = (sti[14:12] <= 3'd6) && (sti[11:7] <= 5'd23) &&
                     (sti[6:4] <= 3'd5) && (sti[3:0] <= 4'd9);
                if (ok) m_q[sti[14:12]] = {sti[15], sti[11:0]};
                else    m_err = 1'b1;
            end
            case (m_state)
                0: if (hit) begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (stp) m_state = 0;
                    else if (snz) begin m_state = 2; m_cnt = 0; end
                    else if (tick) begin
                        m_cnt++;
                        if (m_cnt == RING) m_state = 0;
                    end
                end
                default: begin
                    if (stp) m_state = 0;
                    else if (tick) begin
                        m_cnt++;
                        if (m_cnt == SNOOZE) begin m_state = 1; m_cnt = 0; end
                    end
                end
            endcase
            m_alarm = (m_state == 1);
        end
        sb.push_back({m_alarm, m_err, m_q[0], m_q[1], m_q[2], m_q[3], m_q[4], m_q[5], m_q[6]});
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL reset: dut=%h model=%h", dut_obs, exp_o);
            end
        end
        checks++;
        if ({ALARM, ERR, Q_r0, Q_r6} !== 28'h0) begin
            failures++;
            $display("FAIL reset_const: got=%h want=0", {ALARM, ERR, Q_r0, Q_r6});
        end
    endtask

    task automatic test_write();
        drive(1'b0, 16'h9A15, 1'b1, CT_MISS, 1'b0, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o) begin
            failures++;
            $display("FAIL write: dut=%h model=%h", dut_obs, exp_o);
        end
        checks++;
        if (Q_r1 !== 13'h1A15 || ERR !== 1'b0 || Q_r0 !== 13'h0 || Q_r2 !== 13'h0) begin
            failures++;
            $display("FAIL write_const: Q_r1=%h ERR=%b want Q_r1=1a15 ERR=0", Q_r1, ERR);
        end
    endtask

    task automatic test_reject();
        logic [15:0] bad [4];
        bad[0] = {1'b1, 3'd1, 5'd24, 3'd1, 4'd5};
        bad[1] = 16'hFA15;
        bad[2] = {1'b1, 3'd1, 5'd20, 3'd6, 4'd5};
        bad[3] = {1'b0, 3'd1, 5'd20, 3'd1, 4'd10};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, bad[i], 1'b1, CT_MISS, 1'b0, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL reject_%0d: dut=%h model=%h", i, dut_obs, exp_o);
            end
            checks++;
            if (ERR !== 1'b1 || Q_r1 !== 13'h1A15) begin
                failures++;
                $display("FAIL reject_err_%0d: ERR=%b Q_r1=%h want 1 1a15", i, ERR, Q_r1);
            end
            drive(1'b0, bad[i], 1'b0, CT_MISS, 1'b0, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o || ERR !== 1'b0) begin
                failures++;
                $display("FAIL reject_pulse_%0d: dut=%h model=%h", i, dut_obs, exp_o);
            end
        end
    endtask

    task automatic test_ring_timeout();
        // Day code 7 with a matching time field must not ring.
        drive(1'b0, 16'h0, 1'b0, {3'd7, 12'hA15}, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b0) begin
            failures++;
            $display("FAIL day7: dut=%h model=%h", dut_obs, exp_o);
        end
        drive(1'b0, 16'h0, 1'b0, CT_HIT, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b1) begin
            failures++;
            $display("FAIL ring_start: dut=%h model=%h ALARM=%b want 1", dut_obs, exp_o, ALARM);
        end
        for (int k = 1; k <= RING; k++) begin
            drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b0, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL ring_gap_%0d: dut=%h model=%h", k, dut_obs, exp_o);
            end
            drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o || ALARM !== (k < RING)) begin
                failures++;
                $display("FAIL ring_tick_%0d: ALARM=%b want %b", k, ALARM, (k < RING));
            end
        end
    endtask

    task automatic test_snooze();
        drive(1'b0, 16'h0, 1'b0, CT_HIT, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b1) begin
            failures++;
            $display("FAIL snz_ring: dut=%h model=%h", dut_obs, exp_o);
        end
        // Snooze together with a tick: snooze takes priority.
        drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b1, 1'b0, 1'b1);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b0) begin
            failures++;
            $display("FAIL snz_enter: ALARM=%b want 0", ALARM);
        end
        for (int k = 1; k <= SNOOZE; k++) begin
            // A snooze press while already snoozed must change nothing.
            drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b0, 1'b0, (k == 4));
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL snz_gap_%0d: dut=%h model=%h", k, dut_obs, exp_o);
            end
            drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o || ALARM !== (k == SNOOZE)) begin
                failures++;
                $display("FAIL snz_tick_%0d: ALARM=%b want %b", k, ALARM, (k == SNOOZE));
            end
        end
        // Stop and snooze together: stop wins.
        drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b0, 1'b1, 1'b1);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b0) begin
            failures++;
            $display("FAIL snz_stop: ALARM=%b want 0", ALARM);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'h0, 1'b0, CT_MISS, 1'b1, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o || ALARM !== 1'b0) begin
                failures++;
                $display("FAIL snz_after_stop_%0d: ALARM=%b want 0", k, ALARM);
            end
        end
    endtask

    task automatic test_same_cycle_write();
        drive(1'b0, 16'h1A15, 1'b1, CT_HIT, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b1 || Q_r1 !== 13'h0A15) begin
            failures++;
            $display("FAIL same_cycle: ALARM=%b Q_r1=%h want 1 0a15", ALARM, Q_r1);
        end
        // Rewriting today's entry while ringing keeps the ring going.
        drive(1'b0, 16'h9A20, 1'b1, CT_MISS, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b1) begin
            failures++;
            $display("FAIL rewrite_ringing: dut=%h model=%h", dut_obs, exp_o);
        end
        drive(1'b0, 16'h9A15, 1'b1, CT_MISS, 1'b0, 1'b1, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b0 || Q_r1 !== 13'h1A15) begin
            failures++;
            $display("FAIL stop_rewrite: ALARM=%b Q_r1=%h want 0 1a15", ALARM, Q_r1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        for (int d = 0; d < 7; d++) begin
            w = {(d % 2 == 0) ? 1'b1 : 1'b0, 3'(d), 5'(d + 3), 3'(d % 6), 4'(d)};
            if (d == 1) w = 16'h9A15;
            if (d == 6) w[15] = 1'b0;
            drive(1'b0, w, 1'b1, CT_MISS, 1'b0, 1'b0, 1'b0);
            exp_o = sb.pop_front();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL b2b_%0d: dut=%h model=%h", d, dut_obs, exp_o);
            end
        end
        checks++;
        if (Q_r6 !== 13'h0486 || Q_r1 !== 13'h1A15 || Q_r0 !== 13'h1180) begin
            failures++;
            $display("FAIL b2b_const: Q_r0=%h Q_r1=%h Q_r6=%h want 1180 1a15 0486", Q_r0, Q_r1, Q_r6);
        end
    endtask

    task automatic test_clear_ringing();
        drive(1'b0, 16'h0, 1'b0, CT_HIT, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b1) begin
            failures++;
            $display("FAIL clr_ring: dut=%h model=%h", dut_obs, exp_o);
        end
        // Clear beats a simultaneous write and stop.
        drive(1'b1, 16'h9A15, 1'b1, CT_HIT, 1'b1, 1'b1, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || dut_obs !== 93'h0) begin
            failures++;
            $display("FAIL clr_all: dut=%h want 0", dut_obs);
        end
        drive(1'b0, 16'h0, 1'b0, CT_HIT, 1'b1, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        checks++;
        if (dut_obs !== exp_o || ALARM !== 1'b0) begin
            failures++;
            $display("FAIL clr_no_ring: ALARM=%b want 0", ALARM);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_reject();
        test_ring_timeout();
        test_snooze();
        test_same_cycle_write();
        test_back_to_back();
        test_clear_ringing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Alarm storage and ringing controller for the alarm clock, and the consumer of the 16-bit set-time word. It holds one 13-bit alarm entry per weekday, writes an entry from a set-time word on command, and exports all seven entries for read-back. Each minute it compares the current time against today's entry and runs the ring/snooze state machine that drives the buzzer.

## Interface
- RING_MIN, 5: minute ticks an unattended alarm rings before it self-cancels (1..15)
- SNOOZE_MIN, 9: minute ticks spent in snooze before ringing resumes (1..15)
- Clk  in  1  system clock; all state changes on the rising edge
- CLEAR  in  1  reset, synchronous and active-high
- STI  in  16  set-time word: [15] alarm on/off, [14:12] day 0..6, [11:7] hour 0..23, [6:4] minute tens 0..5, [3:0] minute units 0..9
- WR_AL  in  1  one-cycle strobe; write STI into the entry selected by STI[14:12]
- CT  in  15  current time: [14:12] day, [11:7] hour, [6:4] minute tens, [3:0] minute units
- MIN_TICK  in  1  one-cycle pulse; CT already holds the new minute in that cycle
- STOP, SNOOZE  in  1 each  user buttons, one-cycle pulses (already debounced)
- Q_r0..Q_r6  out  13 each  entry per day: [12] enable, [11:0] = STI[11:0] layout
- ALARM  out  1  buzzer drive; high in RINGING only
- ERR  out  1  one-cycle pulse: the last WR_AL was rejected

## Operation
- Reset (CLEAR=1): all Q_r = 0, state IDLE, counter 0, ALARM = 0, ERR = 0. CLEAR overrides every other input, including a reset while RINGING or SNOOZED.
- Write: when WR_AL=1, entry[STI[14:12]] ← {STI[15], STI[11:0]}. The write is rejected (no change, ERR=1 next cycle) if day=7, hour>23, tens>5 or units>9.
- Match: requires MIN_TICK=1 and entry[CT day].enable=1 and entry[11:0]==CT[11:0]. The compare uses the entry contents before any write in the same cycle.
- FSM states IDLE, RINGING, SNOOZED; 4-bit minute counter CNT.
  - IDLE → RINGING on match; CNT←0.
  - RINGING:
    - STOP → IDLE.
    - else SNOOZE → SNOOZED, CNT←0.
    - else MIN_TICK: CNT+1; when CNT+1==RING_MIN → IDLE.
  - SNOOZED:
    - STOP → IDLE.
    - MIN_TICK: CNT+1; when CNT+1==SNOOZE_MIN → RINGING, CNT←0.
    - SNOOZE is ignored.
- Priority in one cycle: CLEAR > STOP > SNOOZE > MIN_TICK count.
- A match while RINGING or SNOOZED is ignored; there is no re-trigger and no queueing.
- Disabling or rewriting today's entry while RINGING or SNOOZED does not stop the ring; only STOP, the timeout or CLEAR do.
- Day wrap (6→0) is handled by the time source; this block only indexes entry[CT day]. A CT day of 7 never matches.

## Timing
- Write latency 1: Q_r updated on the edge after WR_AL. Back-to-back writes are allowed, one per cycle.
- ALARM rises on the edge after the matching MIN_TICK; falls on the edge after STOP/SNOOZE/timeout.
- Ring duration with no user action: exactly RING_MIN MIN_TICK pulses after the match tick.
- ERR is high exactly one cycle, on the edge after a rejected WR_AL.
- All outputs are registered; nothing is combinational from inputs.

## Structure
- Shared package `alarm_pkg`:
  - STI/CT field bit positions and widths
  - Limits: 23, 5, 9, day max 6
  - FSM state encoding (2 bits)
  - Entry width 13
- Sub-module `minute_down_counter`: 4-bit load/enable counter with terminal flag, reused for both the ring and snooze limits; the FSM loads RING_MIN or SNOOZE_MIN.
- Entry storage: seven 13-bit registers with per-day write decode; Q_r0..Q_r6 are wired directly from the registers.

## Test plan
- Write STI=0x9A15 (on, day 1, 20:15) with WR_AL → Q_r1=0x1A15 next cycle; ERR=0; other entries unchanged.
- Write hour 24 (STI[11:7]=24) or day 7 → all Q_r unchanged; ERR pulses exactly one cycle.
- Entry day 1 = 20:15 enabled; CT=day 1 20:15 with MIN_TICK → ALARM=1 next cycle. Five further ticks with no button → ALARM=0 after the 5th.
- Ringing, SNOOZE → ALARM=0. Nine MIN_TICKs → ALARM=1 after the 9th. STOP → ALARM=0 and IDLE; further ticks keep ALARM=0.
- WR_AL disabling day 1 in the same cycle as the matching MIN_TICK → ALARM still rises; Q_r1[12]=0 next cycle.
- CLEAR while RINGING → ALARM=0, all Q_r=0 next cycle; no ring on a later matching tick.
